// File: rtl/autotype_if.sv
// Character feed plus keyboard event buses between the OSD-side injector client and autotype.
interface autotype_if;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic [10:0] user_key;
    logic [10:0] ps2_key;
    logic        busy;

    modport master (
        output char_data, char_valid, user_key,
        input  char_ready, ps2_key, busy
    );

    modport slave (
        input  char_data, char_valid, user_key,
        output char_ready, ps2_key, busy
    );
endinterface

// File: rtl/autotype.sv
// ASCII-to-PS/2 keystroke injector merged with live keyboard events; user events pass through in 1 clk.
// Character input is valid/ready against a FIFO_DEPTH FIFO; char_ready drops only when the FIFO is full.
module autotype #(
    parameter int FIFO_DEPTH  = 16,
    parameter int HOLD_CYCLES = 2000000,
    parameter int GAP_CYCLES  = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    autotype_if.slave  bus
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [7:0]    SHIFT_CODE = 8'h12;

    typedef enum logic [3:0] {
        S_IDLE, S_LOOKUP, S_SHIFT_DN, S_KEY_DN, S_HOLD,
        S_KEY_UP, S_SHIFT_UP, S_GAP, S_ABORT
    } state_t;

    typedef struct packed {
        logic       mapped;
        logic       shifted;
        logic [7:0] code;
    } lut_t;

    function automatic lut_t map_char(input logic [7:0] c);
        lut_t       r;
        logic [7:0] lc;
        r        = '0;
        r.mapped = 1'b1;
        lc       = c;
        if (c >= 8'h41 && c <= 8'h5A) begin
            lc        = c | 8'h20;
            r.shifted = 1'b1;
        end
        case (lc)
            8'h61: r.code = 8'h1C;  8'h62: r.code = 8'h32;  8'h63: r.code = 8'h21;
            8'h64: r.code = 8'h23;  8'h65: r.code = 8'h24;  8'h66: r.code = 8'h2B;
            8'h67: r.code = 8'h34;  8'h68: r.code = 8'h33;  8'h69: r.code = 8'h43;
            8'h6A: r.code = 8'h3B;  8'h6B: r.code = 8'h42;  8'h6C: r.code = 8'h4B;
            8'h6D: r.code = 8'h3A;  8'h6E: r.code = 8'h31;  8'h6F: r.code = 8'h44;
            8'h70: r.code = 8'h4D;  8'h71: r.code = 8'h15;  8'h72: r.code = 8'h2D;
            8'h73: r.code = 8'h1B;  8'h74: r.code = 8'h2C;  8'h75: r.code = 8'h3C;
            8'h76: r.code = 8'h2A;  8'h77: r.code = 8'h1D;  8'h78: r.code = 8'h22;
            8'h79: r.code = 8'h35;  8'h7A: r.code = 8'h1A;
            8'h30: r.code = 8'h45;  8'h31: r.code = 8'h16;  8'h32: r.code = 8'h1E;
            8'h33: r.code = 8'h26;  8'h34: r.code = 8'h25;  8'h35: r.code = 8'h2E;
            8'h36: r.code = 8'h36;  8'h37: r.code = 8'h3D;  8'h38: r.code = 8'h3E;
            8'h39: r.code = 8'h46;
            8'h20: r.code = 8'h29;  8'h0D: r.code = 8'h5A;
            8'h2E: r.code = 8'h49;  8'h2C: r.code = 8'h41;
            8'h2F: r.code = 8'h4A;  8'h2D: r.code = 8'h4E;
            8'h22: begin r.code = 8'h1E; r.shifted = 1'b1; end
            8'h21: begin r.code = 8'h16; r.shifted = 1'b1; end
            8'h3F: begin r.code = 8'h4A; r.shifted = 1'b1; end
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    code_q, code_d;
    logic          shift_held_q, shift_held_d;
    logic          key_held_q, key_held_d;
    logic [10:0]   ps2_key_q, ps2_key_d;
    logic          user_prev_q;

    logic [PW-1:0] count;
    logic          empty, full, busy;
    logic          pt_evt, abort, push, pop, fsm_emit;
    logic [9:0]    fsm_dat;
    lut_t          lk;

    assign count          = wr_ptr_q - rd_ptr_q;
    assign empty          = (count == '0);
    assign full           = (count == PW'(FIFO_DEPTH));
    assign busy           = (state_q != S_IDLE) | ~empty;
    assign bus.busy       = busy;
    assign bus.char_ready = ~reset & ~full;
    assign bus.ps2_key    = ps2_key_q;

    always_comb begin
        pt_evt       = bus.user_key[10] ^ user_prev_q;
        abort        = pt_evt & bus.user_key[9] & busy;
        push         = bus.char_valid & bus.char_ready & ~abort;
        pop          = 1'b0;
        fsm_emit     = 1'b0;
        fsm_dat      = '0;
        lk           = map_char(mem_q[rd_ptr_q[AW-1:0]]);
        state_d      = state_q;
        cnt_d        = cnt_q;
        code_d       = code_q;
        shift_held_d = shift_held_q;
        key_held_d   = key_held_q;
        ps2_key_d    = ps2_key_q;

        // Emitting states only advance on a clock the pass-through does not claim.
        case (state_q)
            S_IDLE: if (!empty) state_d = S_LOOKUP;
            S_LOOKUP: begin
                pop     = 1'b1;
                code_d  = lk.code;
                state_d = !lk.mapped ? S_IDLE : (lk.shifted ? S_SHIFT_DN : S_KEY_DN);
            end
            S_SHIFT_DN: begin
                fsm_emit = 1'b1;
                fsm_dat  = {2'b10, SHIFT_CODE};
                if (!pt_evt) begin
                    shift_held_d = 1'b1;
                    state_d      = S_KEY_DN;
                end
            end
            S_KEY_DN: begin
                fsm_emit = 1'b1;
                fsm_dat  = {2'b10, code_q};
                if (!pt_evt) begin
                    key_held_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = S_KEY_UP;
                else                    cnt_d   = cnt_q + CW'(1);
            end
            S_KEY_UP: begin
                fsm_emit = 1'b1;
                fsm_dat  = {2'b00, code_q};
                if (!pt_evt) begin
                    key_held_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = shift_held_q ? S_SHIFT_UP : S_GAP;
                end
            end
            S_SHIFT_UP: begin
                fsm_emit = 1'b1;
                fsm_dat  = {2'b00, SHIFT_CODE};
                if (!pt_evt) begin
                    shift_held_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) state_d = S_IDLE;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            S_ABORT: begin
                if (key_held_q) begin
                    fsm_emit = 1'b1;
                    fsm_dat  = {2'b00, code_q};
                    if (!pt_evt) begin
                        key_held_d = 1'b0;
                        state_d    = shift_held_q ? S_ABORT : S_IDLE;
                    end
                end else if (shift_held_q) begin
                    fsm_emit = 1'b1;
                    fsm_dat  = {2'b00, SHIFT_CODE};
                    if (!pt_evt) begin
                        shift_held_d = 1'b0;
                        state_d      = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) state_d = S_ABORT;

        if (pt_evt)        ps2_key_d = {~ps2_key_q[10], bus.user_key[9:0]};
        else if (fsm_emit) ps2_key_d = {~ps2_key_q[10], fsm_dat};

        // A user press while busy discards everything queued, including this clock's write.
        if (abort) begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.char_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            code_q       <= '0;
            shift_held_q <= 1'b0;
            key_held_q   <= 1'b0;
            ps2_key_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            user_prev_q  <= bus.user_key[10];
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            shift_held_q <= shift_held_d;
            key_held_q   <= key_held_d;
            ps2_key_q    <= ps2_key_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            user_prev_q  <= bus.user_key[10];
        end
    end
endmodule
